// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: picks one writeback requester per cycle and registers the write.
// Round-robin by default; define RF_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module rf_write_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic               wr_en,
    output logic [AW-1:0]      a3,
    output logic [DW-1:0]      wd,
    input  logic [AW-1:0]      rd_addr1,
    input  logic [AW-1:0]      rd_addr2,
    output logic               hazard1,
    output logic               hazard2,
    output logic               busy
);

    localparam int PW = (NREQ > 2) ? 2 : 1;
    localparam int SW = PW + 1;

    logic [NREQ-1:0] gnt_c;
    logic            grant_valid;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

`ifdef RF_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_c = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_c    = '0;
                gnt_c[i] = 1'b1;
            end
        end
    end
`else
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gnt_idx;
    logic [SW-1:0] scan;
    logic          found;

    // Scan the requesters cyclically starting at rr_ptr; first asserted one wins.
    always_comb begin
        gnt_c = '0;
        found = 1'b0;
        scan  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, rr_ptr} + SW'(k);
            if (scan >= SW'(NREQ)) begin
                scan = scan - SW'(NREQ);
            end
            if (!found && req[scan[PW-1:0]]) begin
                gnt_c[scan[PW-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = PW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

    assign gnt = rst_n ? gnt_c : '0;

    always_comb begin
        grant_valid = |gnt;
        sel_addr    = '0;
        sel_data    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // A transfer to r0 is accepted but never reaches the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en <= 1'b0;
            a3    <= '0;
            wd    <= '0;
        end else if (grant_valid) begin
            wr_en <= (sel_addr != '0);
            a3    <= sel_addr;
            wd    <= sel_data;
        end else begin
            wr_en <= 1'b0;
        end
    end

    // The write-stage register commits at the negedge, so only pending requests count.
    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && (req_addr[i*AW +: AW] == rd_addr1) && (rd_addr1 != '0)) begin
                hazard1 = 1'b1;
            end
            if (req[i] && (req_addr[i*AW +: AW] == rd_addr2) && (rd_addr2 != '0)) begin
                hazard2 = 1'b1;
            end
        end
    end

    assign busy = (|req) | wr_en;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: reset-time hazard table, directed corner cases
// and randomized handshaking requesters compared against a rule-level reference model.
module tb_rf_write_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b1;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic               wr_en;
    logic [AW-1:0]      a3;
    logic [DW-1:0]      wd;
    logic [AW-1:0]      rd_addr1;
    logic [AW-1:0]      rd_addr2;
    logic               hazard1;
    logic               hazard2;
    logic               busy;

    int n_checks = 0;
    int n_errors = 0;

    int            exp_start;
    logic          exp_wr_en;
    logic [AW-1:0] exp_a3;
    logic [DW-1:0] exp_wd;
    int            last_grant;

    logic [DW-1:0] rf [32];

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .wr_en(wr_en), .a3(a3), .wd(wd), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .hazard1(hazard1), .hazard2(hazard2), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register-file stand-in that commits on the falling edge.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wr_en) begin
            rf[a3] <= wd;
        end
    end

    typedef struct {
        logic [NREQ-1:0] r;
        logic [AW-1:0]   a0, a1, rd1, rd2;
        logic            h1, h2;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [AW-1:0] getAddr(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] getData(input int i);
        return req_data[i*DW +: DW];
    endfunction

    function automatic int modelGrant(input logic [NREQ-1:0] r, input int start);
`ifdef RF_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (r[i]) return i;
        if (start < 0) return -1;
`else
        for (int k = 0; k < NREQ; k++) if (r[(start + k) % NREQ]) return (start + k) % NREQ;
`endif
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                 input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        req      = r;
        req_addr = {a1, a0};
        req_data = {d1, d0};
        rd_addr1 = r1;
        rd_addr2 = r2;
    endtask

    task automatic resetModel();
        exp_start  = 0;
        exp_wr_en  = 1'b0;
        exp_a3     = '0;
        exp_wd     = '0;
        last_grant = -1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req   = '0;
        @(posedge clk);
        @(posedge clk);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Compares every output against the model mid-cycle, then advances the model at the posedge.
    task automatic modelCycle();
        int              g;
        logic [NREQ-1:0] eg;
        logic            eh1, eh2;
        #1;
        g  = modelGrant(req, exp_start);
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        eh1 = 1'b0;
        eh2 = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && rd_addr1 != '0 && getAddr(i) == rd_addr1) eh1 = 1'b1;
            if (req[i] && rd_addr2 != '0 && getAddr(i) == rd_addr2) eh2 = 1'b1;
        end
        checkOutput("gnt", 64'(gnt), 64'(eg));
        checkOutput("wr_en", 64'(wr_en), 64'(exp_wr_en));
        checkOutput("a3", 64'(a3), 64'(exp_a3));
        checkOutput("wd", 64'(wd), 64'(exp_wd));
        checkOutput("hazard1", 64'(hazard1), 64'(eh1));
        checkOutput("hazard2", 64'(hazard2), 64'(eh2));
        checkOutput("busy", 64'(busy), 64'((|req) || exp_wr_en));
        @(posedge clk);
        last_grant = g;
        if (g >= 0) begin
            exp_wr_en = (getAddr(g) != '0);
            exp_a3    = getAddr(g);
            exp_wd    = getData(g);
            exp_start = (g + 1) % NREQ;
        end else begin
            exp_wr_en = 1'b0;
        end
        #2;
    endtask

    initial begin
        logic [NREQ-1:0] rr;
        logic [AW-1:0]   ad [NREQ];
        logic [DW-1:0]   da [NREQ];
        logic [1:0]      cont_exp [4];

        tbl[0] = '{r: 2'b11, a0: 5'd9, a1: 5'd3, rd1: 5'd9, rd2: 5'd3, h1: 1'b1, h2: 1'b1};
        tbl[1] = '{r: 2'b01, a0: 5'd9, a1: 5'd3, rd1: 5'd3, rd2: 5'd9, h1: 1'b0, h2: 1'b1};
        tbl[2] = '{r: 2'b10, a0: 5'd9, a1: 5'd3, rd1: 5'd3, rd2: 5'd9, h1: 1'b1, h2: 1'b0};
        tbl[3] = '{r: 2'b11, a0: 5'd0, a1: 5'd0, rd1: 5'd0, rd2: 5'd0, h1: 1'b0, h2: 1'b0};
        tbl[4] = '{r: 2'b00, a0: 5'd5, a1: 5'd5, rd1: 5'd5, rd2: 5'd5, h1: 1'b0, h2: 1'b0};
        tbl[5] = '{r: 2'b11, a0: 5'd6, a1: 5'd6, rd1: 5'd6, rd2: 5'd7, h1: 1'b1, h2: 1'b0};
`ifdef RF_ARB_FIXED_PRIO_EN
        cont_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        cont_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

        applyStimulus(2'b00, '0, '0, '0, '0, '0, '0);
        #1 rst_n = 1'b0;
        #11;

        // Hazards are combinational and must evaluate while reset holds grants off.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i].r, tbl[i].a0, tbl[i].a1, 32'h1, 32'h2, tbl[i].rd1, tbl[i].rd2);
            #2;
            checkOutput("tbl_hazard1", 64'(hazard1), 64'(tbl[i].h1));
            checkOutput("tbl_hazard2", 64'(hazard2), 64'(tbl[i].h2));
            checkOutput("tbl_gnt", 64'(gnt), 64'(2'b00));
            checkOutput("tbl_busy", 64'(busy), 64'(|tbl[i].r));
        end

        applyStimulus(2'b11, 5'd3, 5'd4, 32'h11111111, 32'h22222222, '0, '0);
        @(posedge clk);
        #2;
        checkOutput("rst_gnt", 64'(gnt), 64'(2'b00));
        checkOutput("rst_wr_en", 64'(wr_en), 64'(1'b0));
        checkOutput("rst_a3", 64'(a3), 64'(5'd0));
        checkOutput("rst_wd", 64'(wd), 64'(32'd0));
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("rst_first_gnt", 64'(gnt), 64'(2'b01));
        modelCycle();
        applyStimulus(2'b10, 5'd3, 5'd4, 32'h11111111, 32'h22222222, '0, '0);
        modelCycle();
        applyStimulus(2'b00, 5'd3, 5'd4, 32'h11111111, 32'h22222222, '0, '0);
        modelCycle();
        modelCycle();

        // Single write through to the register file.
        doReset();
        applyStimulus(2'b10, 5'd0, 5'd7, 32'h0, 32'hDEADBEEF, '0, '0);
        #1 checkOutput("single_gnt", 64'(gnt), 64'(2'b10));
        modelCycle();
        applyStimulus(2'b00, 5'd0, 5'd7, 32'h0, 32'hDEADBEEF, '0, '0);
        #1;
        checkOutput("single_wr_en", 64'(wr_en), 64'(1'b1));
        checkOutput("single_a3", 64'(a3), 64'(5'd7));
        checkOutput("single_wd", 64'(wd), 64'(32'hDEADBEEF));
        modelCycle();
        checkOutput("single_rf7", 64'(rf[7]), 64'(32'hDEADBEEF));

        // Two requesters held continuously.
        doReset();
        applyStimulus(2'b11, 5'd10, 5'd11, 32'hA0A0A0A0, 32'hB1B1B1B1, '0, '0);
        for (int i = 0; i < 4; i++) begin
            #1 checkOutput("cont_gnt", 64'(gnt), 64'(cont_exp[i]));
            modelCycle();
            if (i > 0) checkOutput("cont_wr_en", 64'(wr_en), 64'(1'b1));
        end
        applyStimulus(2'b00, 5'd10, 5'd11, 32'hA0A0A0A0, 32'hB1B1B1B1, '0, '0);
        modelCycle();
        modelCycle();

        // Register 0 is granted but never written.
        doReset();
        applyStimulus(2'b01, 5'd0, 5'd1, 32'hFFFFFFFF, 32'h0, '0, '0);
        #1 checkOutput("r0_gnt", 64'(gnt), 64'(2'b01));
        modelCycle();
        applyStimulus(2'b00, 5'd0, 5'd1, 32'hFFFFFFFF, 32'h0, '0, '0);
        #1 checkOutput("r0_wr_en", 64'(wr_en), 64'(1'b0));
        modelCycle();
        checkOutput("r0_rf0", 64'(rf[0]), 64'(32'h0));

        // Read-after-write hazard on a pending request.
        doReset();
        applyStimulus(2'b11, 5'd5, 5'd9, 32'h5, 32'h9, 5'd9, 5'd0);
        #1;
        checkOutput("haz_h1", 64'(hazard1), 64'(1'b1));
        checkOutput("haz_h2", 64'(hazard2), 64'(1'b0));
        checkOutput("haz_gnt", 64'(gnt), 64'(2'b01));
        modelCycle();
        applyStimulus(2'b10, 5'd5, 5'd9, 32'h5, 32'h9, 5'd9, 5'd0);
        #1;
        checkOutput("haz_h1_wait", 64'(hazard1), 64'(1'b1));
        checkOutput("haz_gnt1", 64'(gnt), 64'(2'b10));
        modelCycle();
        applyStimulus(2'b00, 5'd5, 5'd9, 32'h5, 32'h9, 5'd9, 5'd0);
        #1 checkOutput("haz_h1_drop", 64'(hazard1), 64'(1'b0));
        modelCycle();

        // Same destination from both requesters: the later grant's data must survive.
        doReset();
        applyStimulus(2'b11, 5'd12, 5'd12, 32'hAAAA0000, 32'hBBBB1111, '0, '0);
        modelCycle();
        applyStimulus(2'b10, 5'd12, 5'd12, 32'hAAAA0000, 32'hBBBB1111, '0, '0);
        modelCycle();
        applyStimulus(2'b00, 5'd12, 5'd12, 32'hAAAA0000, 32'hBBBB1111, '0, '0);
        modelCycle();
        modelCycle();
        checkOutput("same_rf12", 64'(rf[12]), 64'(32'hBBBB1111));

        // Reset during an in-flight write.
        doReset();
        applyStimulus(2'b11, 5'd3, 5'd4, 32'h33, 32'h44, '0, '0);
        modelCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_wr_en", 64'(wr_en), 64'(1'b0));
        checkOutput("midrst_gnt", 64'(gnt), 64'(2'b00));
        checkOutput("midrst_a3", 64'(a3), 64'(5'd0));
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("midrst_resume_gnt", 64'(gnt), 64'(2'b01));
        modelCycle();
        applyStimulus(2'b10, 5'd3, 5'd4, 32'h33, 32'h44, '0, '0);
        modelCycle();
        applyStimulus(2'b00, 5'd3, 5'd4, 32'h33, 32'h44, '0, '0);
        modelCycle();

        // Randomized requesters that hold until granted.
        doReset();
        rr = '0;
        for (int i = 0; i < NREQ; i++) begin
            ad[i] = '0;
            da[i] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rr[i] || last_grant == i) begin
                    rr[i] = ($urandom_range(0, 3) != 0);
                    ad[i] = AW'($urandom_range(0, 7));
                    da[i] = $urandom;
                end
            end
            applyStimulus(rr, ad[0], ad[1], da[0], da[1],
                          AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            modelCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
